// File: rtl/nice_mem_scheduler.sv
// nice_mem_scheduler
//   Sequences one accelerator job over the single NICE ICB memory port:
//   an LHS load phase, an RHS load phase and a DST store phase, in that
//   order. A phase with a word count of zero is skipped. The block generates
//   word addresses, limits the number of outstanding ICB commands, forwards
//   read data to the datapath, and pops store words from the datapath.
//
// Ports
//   nice_clk, nice_rst_n       clock, asynchronous active-low reset
//   job_start                  start pulse, only looked at while idle
//   cfg_{lhs,rhs,dst}_base     per-phase byte base addresses (word aligned)
//   cfg_{lhs,rhs,dst}_words    per-phase word counts (0 = skip phase)
//   job_busy/job_done/job_err  job status: busy, one-cycle done, sticky error
//   nice_icb_cmd_*             ICB command channel (master side)
//   nice_icb_rsp_*             ICB response channel (master side)
//   nice_mem_holdup            job_busy delayed by one register stage
//   rd_data_valid/rd_data/rd_sel   read words to the datapath (sel 0=LHS, 1=RHS)
//   wr_data/wr_data_valid/wr_data_ready   store words from the datapath
module nice_mem_scheduler #(
    parameter int CNT_W  = 10,
    parameter int MAX_OT = 2
) (
    input  logic             nice_clk,
    input  logic             nice_rst_n,
    input  logic             job_start,
    input  logic [31:0]      cfg_lhs_base,
    input  logic [31:0]      cfg_rhs_base,
    input  logic [31:0]      cfg_dst_base,
    input  logic [CNT_W-1:0] cfg_lhs_words,
    input  logic [CNT_W-1:0] cfg_rhs_words,
    input  logic [CNT_W-1:0] cfg_dst_words,
    output logic             job_busy,
    output logic             job_done,
    output logic             job_err,
    output logic             nice_icb_cmd_valid,
    input  logic             nice_icb_cmd_ready,
    output logic [31:0]      nice_icb_cmd_addr,
    output logic             nice_icb_cmd_read,
    output logic [31:0]      nice_icb_cmd_wdata,
    output logic [1:0]       nice_icb_cmd_size,
    input  logic             nice_icb_rsp_valid,
    output logic             nice_icb_rsp_ready,
    input  logic [31:0]      nice_icb_rsp_rdata,
    input  logic             nice_icb_rsp_err,
    output logic             nice_mem_holdup,
    output logic             rd_data_valid,
    output logic [31:0]      rd_data,
    output logic             rd_sel,
    input  logic [31:0]      wr_data,
    input  logic             wr_data_valid,
    output logic             wr_data_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LHS,
        S_RHS,
        S_DST,
        S_DRAIN,
        S_DONE
    } state_e;

    // Outstanding counter is sized for the largest supported MAX_OT (3).
    localparam int OT_W = 2;

    state_e           state_q, state_d;
    logic [31:0]      lhs_base_q, lhs_base_d;
    logic [31:0]      rhs_base_q, rhs_base_d;
    logic [31:0]      dst_base_q, dst_base_d;
    logic [CNT_W-1:0] lhs_words_q, lhs_words_d;
    logic [CNT_W-1:0] rhs_words_q, rhs_words_d;
    logic [CNT_W-1:0] dst_words_q, dst_words_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [OT_W-1:0]  ot_q, ot_d;
    logic             err_seen_q, err_seen_d;
    logic             job_err_q, job_err_d;
    logic             drain_read_q, drain_read_d;
    logic             drain_sel_q, drain_sel_d;
    logic             holdup_q;

    logic             in_phase;
    logic             is_dst;
    logic [31:0]      cur_base;
    logic [CNT_W-1:0] cur_words;
    logic             cmd_hs;
    logic             rsp_hs;
    logic [OT_W-1:0]  ot_nxt;

    // Picks the first phase with work, in LHS > RHS > DST priority.
    function automatic state_e first_phase(input logic l, input logic r, input logic d);
        if (l)      return S_LHS;
        else if (r) return S_RHS;
        else if (d) return S_DST;
        else        return S_DONE;
    endfunction

    // Base address and word count of the phase currently being worked on.
    always_comb begin
        cur_base  = lhs_base_q;
        cur_words = lhs_words_q;
        case (state_q)
            S_RHS: begin
                cur_base  = rhs_base_q;
                cur_words = rhs_words_q;
            end
            S_DST: begin
                cur_base  = dst_base_q;
                cur_words = dst_words_q;
            end
            default: ;
        endcase
    end

    assign in_phase = (state_q == S_LHS) || (state_q == S_RHS) || (state_q == S_DST);
    assign is_dst   = (state_q == S_DST);

    // Address and write data depend only on registered state, so they stay
    // stable while a command waits for ready (provided wr_data is held).
    assign nice_icb_cmd_valid = in_phase && (issue_cnt_q < cur_words) &&
                                (ot_q < OT_W'(MAX_OT)) && !err_seen_q &&
                                (!is_dst || wr_data_valid);
    assign nice_icb_cmd_addr  = cur_base + {{(30-CNT_W){1'b0}}, issue_cnt_q, 2'b00};
    assign nice_icb_cmd_read  = (state_q == S_LHS) || (state_q == S_RHS);
    assign nice_icb_cmd_wdata = is_dst ? wr_data : 32'd0;
    assign nice_icb_cmd_size  = 2'b10;
    assign nice_icb_rsp_ready = job_busy;

    assign cmd_hs = nice_icb_cmd_valid && nice_icb_cmd_ready;
    assign rsp_hs = nice_icb_rsp_valid && nice_icb_rsp_ready;

    // Errored read responses are swallowed; a clean response that arrives
    // while draining a read phase is still forwarded.
    assign rd_data_valid = rsp_hs && !nice_icb_rsp_err &&
                           (nice_icb_cmd_read || ((state_q == S_DRAIN) && drain_read_q));
    assign rd_data       = nice_icb_rsp_rdata;
    assign rd_sel        = (state_q == S_RHS) || ((state_q == S_DRAIN) && drain_sel_q);
    assign wr_data_ready = cmd_hs && is_dst;

    assign job_busy        = (state_q != S_IDLE);
    assign job_done        = (state_q == S_DONE);
    assign job_err         = job_err_q;
    assign nice_mem_holdup = holdup_q;

    // Outstanding-command count after this cycle's handshakes.
    always_comb begin
        ot_nxt = ot_q;
        if (cmd_hs && !rsp_hs)
            ot_nxt = ot_q + OT_W'(1);
        else if (!cmd_hs && rsp_hs && (ot_q != '0))
            ot_nxt = ot_q - OT_W'(1);
    end

    // Next-state logic for the job sequencer and its counters.
    always_comb begin
        state_d      = state_q;
        lhs_base_d   = lhs_base_q;
        rhs_base_d   = rhs_base_q;
        dst_base_d   = dst_base_q;
        lhs_words_d  = lhs_words_q;
        rhs_words_d  = rhs_words_q;
        dst_words_d  = dst_words_q;
        issue_cnt_d  = issue_cnt_q;
        rsp_cnt_d    = rsp_cnt_q;
        ot_d         = ot_q;
        err_seen_d   = err_seen_q;
        job_err_d    = job_err_q;
        drain_read_d = drain_read_q;
        drain_sel_d  = drain_sel_q;
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    lhs_base_d  = cfg_lhs_base;
                    rhs_base_d  = cfg_rhs_base;
                    dst_base_d  = cfg_dst_base;
                    lhs_words_d = cfg_lhs_words;
                    rhs_words_d = cfg_rhs_words;
                    dst_words_d = cfg_dst_words;
                    issue_cnt_d = '0;
                    rsp_cnt_d   = '0;
                    ot_d        = '0;
                    err_seen_d  = 1'b0;
                    job_err_d   = 1'b0;
                    state_d     = first_phase(cfg_lhs_words != '0, cfg_rhs_words != '0,
                                              cfg_dst_words != '0);
                end
            end
            S_LHS, S_RHS, S_DST: begin
                ot_d = ot_nxt;
                if (cmd_hs) issue_cnt_d = issue_cnt_q + CNT_W'(1);
                if (rsp_hs) rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
                if (rsp_hs && nice_icb_rsp_err) begin
                    // Stop issuing and wait for whatever is still in flight.
                    err_seen_d   = 1'b1;
                    job_err_d    = 1'b1;
                    drain_read_d = !is_dst;
                    drain_sel_d  = (state_q == S_RHS);
                    state_d      = (ot_nxt == '0) ? S_DONE : S_DRAIN;
                end else if (rsp_hs && ((rsp_cnt_q + CNT_W'(1)) == cur_words)) begin
                    issue_cnt_d = '0;
                    rsp_cnt_d   = '0;
                    case (state_q)
                        S_LHS:   state_d = first_phase(1'b0, rhs_words_q != '0, dst_words_q != '0);
                        S_RHS:   state_d = first_phase(1'b0, 1'b0, dst_words_q != '0);
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_DRAIN: begin
                ot_d = ot_nxt;
                if (ot_nxt == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; holdup is job_busy delayed by one cycle.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            state_q      <= S_IDLE;
            lhs_base_q   <= '0;
            rhs_base_q   <= '0;
            dst_base_q   <= '0;
            lhs_words_q  <= '0;
            rhs_words_q  <= '0;
            dst_words_q  <= '0;
            issue_cnt_q  <= '0;
            rsp_cnt_q    <= '0;
            ot_q         <= '0;
            err_seen_q   <= 1'b0;
            job_err_q    <= 1'b0;
            drain_read_q <= 1'b0;
            drain_sel_q  <= 1'b0;
            holdup_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lhs_base_q   <= lhs_base_d;
            rhs_base_q   <= rhs_base_d;
            dst_base_q   <= dst_base_d;
            lhs_words_q  <= lhs_words_d;
            rhs_words_q  <= rhs_words_d;
            dst_words_q  <= dst_words_d;
            issue_cnt_q  <= issue_cnt_d;
            rsp_cnt_q    <= rsp_cnt_d;
            ot_q         <= ot_d;
            err_seen_q   <= err_seen_d;
            job_err_q    <= job_err_d;
            drain_read_q <= drain_read_d;
            drain_sel_q  <= drain_sel_d;
            holdup_q     <= job_busy;
        end
    end

endmodule

// File: tb/tb_nice_mem_scheduler.sv
// tb_nice_mem_scheduler
//   Directed bench for nice_mem_scheduler. A background memory model answers
//   every accepted command after a programmable delay with data derived from
//   the address, and can flag one chosen response as a bus error. A monitor
//   logs accepted commands, read beats and done pulses; the main sequence
//   compares those logs against hand-computed values.
module tb_nice_mem_scheduler;

    localparam int          CNT_W = 10;
    localparam logic [31:0] KEY   = 32'h5A5A_0000;

    logic             nice_clk;
    logic             nice_rst_n;
    logic             job_start;
    logic [31:0]      cfg_lhs_base, cfg_rhs_base, cfg_dst_base;
    logic [CNT_W-1:0] cfg_lhs_words, cfg_rhs_words, cfg_dst_words;
    logic             job_busy, job_done, job_err;
    logic             nice_icb_cmd_valid, nice_icb_cmd_ready;
    logic [31:0]      nice_icb_cmd_addr;
    logic             nice_icb_cmd_read;
    logic [31:0]      nice_icb_cmd_wdata;
    logic [1:0]       nice_icb_cmd_size;
    logic             nice_icb_rsp_valid, nice_icb_rsp_ready;
    logic [31:0]      nice_icb_rsp_rdata;
    logic             nice_icb_rsp_err;
    logic             nice_mem_holdup;
    logic             rd_data_valid;
    logic [31:0]      rd_data;
    logic             rd_sel;
    logic [31:0]      wr_data;
    logic             wr_data_valid, wr_data_ready;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rspDelay   = 0;
    int errAt      = -1;
    int rspTotal   = 0;
    int doneCnt    = 0;
    int doneCyc    = 0;

    logic [31:0] cmdAddrQ[$];
    logic        cmdReadQ[$];
    logic [31:0] cmdWdataQ[$];
    int          cmdCycQ[$];
    logic [31:0] rdDataQ[$];
    logic        rdSelQ[$];
    int          rdCycQ[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pendQ[$];

    nice_mem_scheduler #(.CNT_W(CNT_W), .MAX_OT(2)) dut (
        .nice_clk           (nice_clk),
        .nice_rst_n         (nice_rst_n),
        .job_start          (job_start),
        .cfg_lhs_base       (cfg_lhs_base),
        .cfg_rhs_base       (cfg_rhs_base),
        .cfg_dst_base       (cfg_dst_base),
        .cfg_lhs_words      (cfg_lhs_words),
        .cfg_rhs_words      (cfg_rhs_words),
        .cfg_dst_words      (cfg_dst_words),
        .job_busy           (job_busy),
        .job_done           (job_done),
        .job_err            (job_err),
        .nice_icb_cmd_valid (nice_icb_cmd_valid),
        .nice_icb_cmd_ready (nice_icb_cmd_ready),
        .nice_icb_cmd_addr  (nice_icb_cmd_addr),
        .nice_icb_cmd_read  (nice_icb_cmd_read),
        .nice_icb_cmd_wdata (nice_icb_cmd_wdata),
        .nice_icb_cmd_size  (nice_icb_cmd_size),
        .nice_icb_rsp_valid (nice_icb_rsp_valid),
        .nice_icb_rsp_ready (nice_icb_rsp_ready),
        .nice_icb_rsp_rdata (nice_icb_rsp_rdata),
        .nice_icb_rsp_err   (nice_icb_rsp_err),
        .nice_mem_holdup    (nice_mem_holdup),
        .rd_data_valid      (rd_data_valid),
        .rd_data            (rd_data),
        .rd_sel             (rd_sel),
        .wr_data            (wr_data),
        .wr_data_valid      (wr_data_valid),
        .wr_data_ready      (wr_data_ready)
    );

    // Free-running clock and cycle counter.
    initial begin
        nice_clk = 1'b0;
        forever #5 nice_clk = ~nice_clk;
    end

    initial begin
        forever begin
            @(posedge nice_clk);
            cyc++;
        end
    end

    // Memory model: handshakes are judged at the negedge, responses are
    // presented just after the following posedge.
    initial begin
        nice_icb_rsp_valid = 1'b0;
        nice_icb_rsp_rdata = 32'd0;
        nice_icb_rsp_err   = 1'b0;
        forever begin
            @(negedge nice_clk);
            if (!nice_rst_n) begin
                pendQ.delete();
            end else begin
                if (nice_icb_rsp_valid && nice_icb_rsp_ready) begin
                    void'(pendQ.pop_front());
                    rspTotal++;
                end
                if (nice_icb_cmd_valid && nice_icb_cmd_ready)
                    pendQ.push_back('{addr: nice_icb_cmd_addr, due: cyc + rspDelay + 1});
            end
            @(posedge nice_clk);
            #1;
            if (pendQ.size() > 0 && cyc >= pendQ[0].due) begin
                nice_icb_rsp_valid = 1'b1;
                nice_icb_rsp_rdata = pendQ[0].addr ^ KEY;
                nice_icb_rsp_err   = (rspTotal == errAt);
            end else begin
                nice_icb_rsp_valid = 1'b0;
                nice_icb_rsp_rdata = 32'd0;
                nice_icb_rsp_err   = 1'b0;
            end
        end
    end

    // Monitor: logs accepted commands, read beats and done pulses.
    initial begin
        forever begin
            @(negedge nice_clk);
            if (nice_rst_n) begin
                if (nice_icb_cmd_valid && nice_icb_cmd_ready) begin
                    cmdAddrQ.push_back(nice_icb_cmd_addr);
                    cmdReadQ.push_back(nice_icb_cmd_read);
                    cmdWdataQ.push_back(nice_icb_cmd_wdata);
                    cmdCycQ.push_back(cyc);
                end
                if (rd_data_valid) begin
                    rdDataQ.push_back(rd_data);
                    rdSelQ.push_back(rd_sel);
                    rdCycQ.push_back(cyc);
                end
                if (job_done) begin
                    doneCnt++;
                    doneCyc = cyc;
                end
            end
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one job_start pulse; returns 2 time units into the first
    // cycle after the start edge.
    task automatic applyStimulus(input logic [31:0] lb, input int lw,
                                 input logic [31:0] rb, input int rw,
                                 input logic [31:0] db, input int dw);
        @(posedge nice_clk);
        #1;
        cfg_lhs_base  = lb;
        cfg_lhs_words = CNT_W'(lw);
        cfg_rhs_base  = rb;
        cfg_rhs_words = CNT_W'(rw);
        cfg_dst_base  = db;
        cfg_dst_words = CNT_W'(dw);
        job_start     = 1'b1;
        @(posedge nice_clk);
        #1;
        job_start = 1'b0;
        #1;
    endtask

    // Waits (bounded) for the job's done pulse, then confirms it was single.
    task automatic waitDone(input int startCnt, input int budget, input string tag);
        int n = 0;
        while (doneCnt == startCnt && n < budget) begin
            @(posedge nice_clk);
            #2;
            n++;
        end
        checkOutput({tag, " done seen"}, 32'((doneCnt > startCnt) ? 1 : 0), 32'd1);
        repeat (3) @(posedge nice_clk);
        #2;
        checkOutput({tag, " single done"}, 32'(doneCnt - startCnt), 32'd1);
        checkOutput({tag, " idle after"}, 32'(job_busy), 32'd0);
    endtask

    int c0, r0, d0;

    initial begin
        nice_rst_n         = 1'b0;
        job_start          = 1'b0;
        cfg_lhs_base       = 32'd0;
        cfg_rhs_base       = 32'd0;
        cfg_dst_base       = 32'd0;
        cfg_lhs_words      = '0;
        cfg_rhs_words      = '0;
        cfg_dst_words      = '0;
        nice_icb_cmd_ready = 1'b0;
        wr_data            = 32'hDEAD_BEEF;
        wr_data_valid      = 1'b0;

        // Reset values
        repeat (2) @(posedge nice_clk);
        #2;
        checkOutput("rst busy", 32'(job_busy), 32'd0);
        checkOutput("rst done", 32'(job_done), 32'd0);
        checkOutput("rst err", 32'(job_err), 32'd0);
        checkOutput("rst cmd_valid", 32'(nice_icb_cmd_valid), 32'd0);
        checkOutput("rst cmd_addr", nice_icb_cmd_addr, 32'd0);
        checkOutput("rst cmd_size", 32'(nice_icb_cmd_size), 32'd2);
        checkOutput("rst rsp_ready", 32'(nice_icb_rsp_ready), 32'd0);
        checkOutput("rst holdup", 32'(nice_mem_holdup), 32'd0);
        checkOutput("rst wr_ready", 32'(wr_data_ready), 32'd0);
        @(posedge nice_clk);
        #1;
        nice_rst_n         = 1'b1;
        nice_icb_cmd_ready = 1'b1;

        // LHS-only job, responses one cycle after acceptance
        $display("[TB] LHS-only job");
        c0 = cmdAddrQ.size(); r0 = rdDataQ.size(); d0 = doneCnt;
        applyStimulus(32'h1000, 4, 32'h0, 0, 32'h0, 0);
        checkOutput("t1 busy", 32'(job_busy), 32'd1);
        checkOutput("t1 first valid", 32'(nice_icb_cmd_valid), 32'd1);
        checkOutput("t1 first addr", nice_icb_cmd_addr, 32'h1000);
        checkOutput("t1 read", 32'(nice_icb_cmd_read), 32'd1);
        checkOutput("t1 wdata zero", nice_icb_cmd_wdata, 32'd0);
        @(posedge nice_clk);
        #2;
        checkOutput("t1 holdup", 32'(nice_mem_holdup), 32'd1);
        waitDone(d0, 100, "t1");
        checkOutput("t1 cmd count", 32'(cmdAddrQ.size() - c0), 32'd4);
        checkOutput("t1 rd count", 32'(rdDataQ.size() - r0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1 addr", cmdAddrQ[c0+i], 32'h1000 + 32'(4*i));
            checkOutput("t1 rd data", rdDataQ[r0+i], (32'h1000 + 32'(4*i)) ^ KEY);
            checkOutput("t1 rd sel", 32'(rdSelQ[r0+i]), 32'd0);
        end
        checkOutput("t1 last rsp to done", 32'(doneCyc - rdCycQ[r0+3]), 32'd1);
        checkOutput("t1 err", 32'(job_err), 32'd0);
        checkOutput("t1 holdup low", 32'(nice_mem_holdup), 32'd0);

        // LHS then RHS
        $display("[TB] LHS+RHS job");
        c0 = cmdAddrQ.size(); r0 = rdDataQ.size(); d0 = doneCnt;
        applyStimulus(32'h1100, 2, 32'h2000, 3, 32'h0, 0);
        waitDone(d0, 100, "t2");
        checkOutput("t2 cmd count", 32'(cmdAddrQ.size() - c0), 32'd5);
        checkOutput("t2 rd count", 32'(rdDataQ.size() - r0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2 addr", cmdAddrQ[c0+i],
                        (i < 2) ? 32'h1100 + 32'(4*i) : 32'h2000 + 32'(4*(i-2)));
            checkOutput("t2 rd sel", 32'(rdSelQ[r0+i]), (i < 2) ? 32'd0 : 32'd1);
        end
        checkOutput("t2 rhs after lhs rsps", 32'((cmdCycQ[c0+2] > rdCycQ[r0+1]) ? 1 : 0), 32'd1);

        // cmd_ready stall mid-phase
        $display("[TB] ready stall");
        c0 = cmdAddrQ.size(); d0 = doneCnt;
        applyStimulus(32'h4000, 6, 32'h0, 0, 32'h0, 0);
        @(posedge nice_clk);
        #1;
        @(posedge nice_clk);
        #1;
        nice_icb_cmd_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("t3 stall valid", 32'(nice_icb_cmd_valid), 32'd1);
            checkOutput("t3 stall addr", nice_icb_cmd_addr, 32'h4008);
            @(posedge nice_clk);
            #2;
        end
        checkOutput("t3 issued during stall", 32'(cmdAddrQ.size() - c0), 32'd2);
        nice_icb_cmd_ready = 1'b1;
        waitDone(d0, 100, "t3");
        checkOutput("t3 cmd count", 32'(cmdAddrQ.size() - c0), 32'd6);
        checkOutput("t3 last addr", cmdAddrQ[c0+5], 32'h4014);

        // Outstanding limit with slow responses; a start while busy is ignored
        $display("[TB] outstanding limit");
        rspDelay = 10;
        c0 = cmdAddrQ.size(); d0 = doneCnt;
        applyStimulus(32'h5000, 4, 32'h0, 0, 32'h0, 0);
        @(posedge nice_clk);
        #2;
        for (int k = 0; k < 6; k++) begin
            @(posedge nice_clk);
            #2;
            checkOutput("t4 capped valid", 32'(nice_icb_cmd_valid), 32'd0);
        end
        checkOutput("t4 accepted while capped", 32'(cmdAddrQ.size() - c0), 32'd2);
        cfg_lhs_base  = 32'h9000;
        cfg_lhs_words = CNT_W'(1);
        job_start     = 1'b1;
        @(posedge nice_clk);
        #1;
        job_start = 1'b0;
        waitDone(d0, 200, "t4");
        checkOutput("t4 cmd count", 32'(cmdAddrQ.size() - c0), 32'd4);
        checkOutput("t4 last addr", cmdAddrQ[c0+3], 32'h500C);
        rspDelay = 0;

        // Bus error on the second response of an 8-word LHS phase
        $display("[TB] response error");
        c0 = cmdAddrQ.size(); r0 = rdDataQ.size(); d0 = doneCnt;
        errAt = rspTotal + 1;
        applyStimulus(32'h6000, 8, 32'h7000, 2, 32'h7800, 2);
        waitDone(d0, 100, "t5");
        errAt = -1;
        checkOutput("t5 cmd count", 32'(cmdAddrQ.size() - c0), 32'd3);
        checkOutput("t5 cmd2 addr", cmdAddrQ[c0+2], 32'h6008);
        checkOutput("t5 rd count", 32'(rdDataQ.size() - r0), 32'd2);
        checkOutput("t5 rd0", rdDataQ[r0], 32'h6000 ^ KEY);
        checkOutput("t5 rd drained", rdDataQ[r0+1], 32'h6008 ^ KEY);
        checkOutput("t5 job_err", 32'(job_err), 32'd1);

        // Store phase with gaps in wr_data_valid
        $display("[TB] store phase");
        c0 = cmdAddrQ.size(); r0 = rdDataQ.size(); d0 = doneCnt;
        wr_data_valid = 1'b0;
        applyStimulus(32'h0, 0, 32'h0, 0, 32'h3000, 3);
        checkOutput("t6 err cleared", 32'(job_err), 32'd0);
        checkOutput("t6 no data no valid", 32'(nice_icb_cmd_valid), 32'd0);
        wr_data       = 32'hD000_0000;
        wr_data_valid = 1'b1;
        #1;
        checkOutput("t6 beat0 valid", 32'(nice_icb_cmd_valid), 32'd1);
        checkOutput("t6 beat0 addr", nice_icb_cmd_addr, 32'h3000);
        checkOutput("t6 beat0 read", 32'(nice_icb_cmd_read), 32'd0);
        checkOutput("t6 beat0 wdata", nice_icb_cmd_wdata, 32'hD000_0000);
        checkOutput("t6 beat0 wr_ready", 32'(wr_data_ready), 32'd1);
        @(posedge nice_clk);
        #1;
        wr_data_valid = 1'b0;
        #1;
        checkOutput("t6 gap valid", 32'(nice_icb_cmd_valid), 32'd0);
        checkOutput("t6 gap wr_ready", 32'(wr_data_ready), 32'd0);
        @(posedge nice_clk);
        #1;
        wr_data       = 32'hD000_0001;
        wr_data_valid = 1'b1;
        #1;
        checkOutput("t6 beat1 addr", nice_icb_cmd_addr, 32'h3004);
        checkOutput("t6 beat1 wdata", nice_icb_cmd_wdata, 32'hD000_0001);
        @(posedge nice_clk);
        #1;
        wr_data_valid = 1'b0;
        @(posedge nice_clk);
        #1;
        wr_data       = 32'hD000_0002;
        wr_data_valid = 1'b1;
        #1;
        checkOutput("t6 beat2 addr", nice_icb_cmd_addr, 32'h3008);
        @(posedge nice_clk);
        #1;
        wr_data_valid = 1'b0;
        waitDone(d0, 100, "t6");
        checkOutput("t6 cmd count", 32'(cmdAddrQ.size() - c0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t6 logged read", 32'(cmdReadQ[c0+i]), 32'd0);
            checkOutput("t6 logged wdata", cmdWdataQ[c0+i], 32'hD000_0000 + 32'(i));
        end
        checkOutput("t6 no rd beats", 32'(rdDataQ.size() - r0), 32'd0);

        // All-zero job
        $display("[TB] empty job");
        c0 = cmdAddrQ.size(); d0 = doneCnt;
        applyStimulus(32'h0, 0, 32'h0, 0, 32'h0, 0);
        waitDone(d0, 2, "t7");
        checkOutput("t7 no cmds", 32'(cmdAddrQ.size() - c0), 32'd0);

        // Address wrap at 2^32
        $display("[TB] address wrap");
        c0 = cmdAddrQ.size(); r0 = rdDataQ.size(); d0 = doneCnt;
        applyStimulus(32'hFFFF_FFF8, 3, 32'h0, 0, 32'h0, 0);
        waitDone(d0, 100, "t8");
        checkOutput("t8 addr0", cmdAddrQ[c0], 32'hFFFF_FFF8);
        checkOutput("t8 addr1", cmdAddrQ[c0+1], 32'hFFFF_FFFC);
        checkOutput("t8 addr2", cmdAddrQ[c0+2], 32'h0000_0000);
        checkOutput("t8 rd2", rdDataQ[r0+2], 32'h0000_0000 ^ KEY);

        // Reset in the middle of a job, then a clean job
        $display("[TB] reset mid-job");
        rspDelay = 10;
        applyStimulus(32'h7000, 4, 32'h0, 0, 32'h0, 0);
        @(posedge nice_clk);
        #2;
        nice_rst_n = 1'b0;
        #1;
        checkOutput("t9 busy in reset", 32'(job_busy), 32'd0);
        checkOutput("t9 valid in reset", 32'(nice_icb_cmd_valid), 32'd0);
        checkOutput("t9 size in reset", 32'(nice_icb_cmd_size), 32'd2);
        repeat (2) @(posedge nice_clk);
        #1;
        nice_rst_n = 1'b1;
        rspDelay   = 0;
        c0 = cmdAddrQ.size(); d0 = doneCnt;
        applyStimulus(32'h8000, 1, 32'h0, 0, 32'h0, 0);
        waitDone(d0, 100, "t9");
        checkOutput("t9 cmd count", 32'(cmdAddrQ.size() - c0), 32'd1);
        checkOutput("t9 addr", cmdAddrQ[c0], 32'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
